// File: rtl/mdu_sequencer_pkg.sv
// Shared types and sizing helpers for the multi-cycle multiply/divide unit.
//   MduStateEnum : sequencer states IDLE -> MULT|DIV -> FIXUP -> IDLE
//   MduOpEnum    : operation latched at start (Mult or Div)
//   CountWidth   : iteration counter width for the default 32-bit datapath
//   count_width(): counter width for an arbitrary operand width
package MduPkg;

  localparam int DefaultDataWidth = 32;

  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int CountWidth = $clog2(DefaultDataWidth + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MULT  = 2'd1,
    DIV   = 2'd2,
    FIXUP = 2'd3
  } MduStateEnum;

  typedef enum logic {
    Mult = 1'b0,
    Div  = 1'b1
  } MduOpEnum;

endpackage

// File: rtl/mdu_sequencer_if.sv
// Core <-> multiply/divide unit request/result bundle.
//   master : the core (drives requests, observes stall/busy/done/hi/lo)
//   slave  : the multiply/divide sequencer
// Signals: enable, start_mult, start_div, is_unsigned, op_a, op_b,
//          wr_hi, wr_lo, wr_data, rd_hilo (requests);
//          stall, busy, done, hi, lo (results/status).
interface mdu_sequencer_if #(
  parameter int DataWidth = 32
);
  logic                 enable;
  logic                 start_mult;
  logic                 start_div;
  logic                 is_unsigned;
  logic [DataWidth-1:0] op_a;
  logic [DataWidth-1:0] op_b;
  logic                 wr_hi;
  logic                 wr_lo;
  logic [DataWidth-1:0] wr_data;
  logic                 rd_hilo;
  logic                 stall;
  logic                 busy;
  logic                 done;
  logic [DataWidth-1:0] hi;
  logic [DataWidth-1:0] lo;

  modport master (
    output enable, start_mult, start_div, is_unsigned, op_a, op_b,
           wr_hi, wr_lo, wr_data, rd_hilo,
    input  stall, busy, done, hi, lo
  );

  modport slave (
    input  enable, start_mult, start_div, is_unsigned, op_a, op_b,
           wr_hi, wr_lo, wr_data, rd_hilo,
    output stall, busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_datapath.sv
// Arithmetic datapath of the multiply/divide unit.
// Holds the 2W accumulator ({upper, lower}), the operand magnitude |b| and
// the result sign flags. Each i_step performs one radix-2 iteration:
//   Mult: upper += |b| when acc[0] is set, then shift the 2W value right.
//   Div : shift {rem, quo} left, trial-subtract |b|, keep on no borrow.
// o_hi_result/o_lo_result present the sign-corrected results for FIXUP.
// Ports:
//   clock, reset   : clock, asynchronous active-high reset
//   i_load         : capture operands (start accepted)
//   i_early_load   : load the trivially resolved result instead
//   i_op           : operation to capture with i_load
//   i_is_unsigned  : operand interpretation
//   i_op_a, i_op_b : multiplicand/dividend, multiplier/divisor
//   i_step         : run one iteration
//   o_trivial      : current request can be resolved without iterating
//   o_hi_result, o_lo_result : final HI/LO values
module mdu_datapath
  import MduPkg::*;
#(
  parameter int DataWidth   = 32,
  parameter bit EarlyExitEn = 1'b0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 i_load,
  input  logic                 i_early_load,
  input  MduOpEnum             i_op,
  input  logic                 i_is_unsigned,
  input  logic [DataWidth-1:0] i_op_a,
  input  logic [DataWidth-1:0] i_op_b,
  input  logic                 i_step,
  output logic                 o_trivial,
  output logic [DataWidth-1:0] o_hi_result,
  output logic [DataWidth-1:0] o_lo_result
);

  localparam int W = DataWidth;

  logic [2*W-1:0] r_acc;
  logic [W-1:0]   r_abs_b;
  MduOpEnum       r_op;
  logic           r_neg_q;
  logic           r_neg_r;

  logic [W-1:0]   w_abs_a;
  logic [W-1:0]   w_abs_b;
  logic           w_trivial_raw;
  logic [2*W-1:0] w_load_acc;
  logic [W:0]     w_sum;
  logic [2*W-1:0] w_mult_next;
  logic [W:0]     w_rem_sh;
  logic [W-1:0]   w_quo_sh;
  logic [W:0]     w_diff;
  logic [2*W-1:0] w_div_next;
  logic [2*W-1:0] w_prod_neg;

  // Magnitude of the most-negative value is simply its own bit pattern.
  assign w_abs_a = (!i_is_unsigned && i_op_a[W-1]) ? (-i_op_a) : i_op_a;
  assign w_abs_b = (!i_is_unsigned && i_op_b[W-1]) ? (-i_op_b) : i_op_b;

  assign w_trivial_raw = (i_op == Mult) ? ((w_abs_a == '0) || (w_abs_b == '0))
                                        : ((w_abs_b != '0) && (w_abs_a < w_abs_b));
  assign o_trivial = EarlyExitEn && w_trivial_raw;

  // Trivial results: product 0, or quotient 0 with remainder |a|.
  always_comb begin
    w_load_acc = {{W{1'b0}}, w_abs_a};
    if (i_early_load) begin
      if (i_op == Mult) w_load_acc = '0;
      else              w_load_acc = {w_abs_a, {W{1'b0}}};
    end
  end

  // Multiply step: the carry of the upper-half add becomes the new MSB.
  assign w_sum       = {1'b0, r_acc[2*W-1:W]} + {1'b0, (r_acc[0] ? r_abs_b : {W{1'b0}})};
  assign w_mult_next = {w_sum, r_acc[W-1:1]};

  // Divide step: the shifted remainder needs W+1 bits; bit W of the
  // difference is the borrow (the remainder is always below 2*|b|).
  assign w_rem_sh   = {r_acc[2*W-1:W], r_acc[W-1]};
  assign w_quo_sh   = {r_acc[W-2:0], 1'b0};
  assign w_diff     = w_rem_sh - {1'b0, r_abs_b};
  assign w_div_next = w_diff[W] ? {w_rem_sh[W-1:0], w_quo_sh}
                                : {w_diff[W-1:0], w_quo_sh | {{(W-1){1'b0}}, 1'b1}};

  assign w_prod_neg = -r_acc;

  always_comb begin
    o_hi_result = r_acc[2*W-1:W];
    o_lo_result = r_acc[W-1:0];
    if (r_op == Mult) begin
      if (r_neg_q) begin
        o_hi_result = w_prod_neg[2*W-1:W];
        o_lo_result = w_prod_neg[W-1:0];
      end
    end else begin
      if (r_neg_r) o_hi_result = -r_acc[2*W-1:W];
      if (r_neg_q) o_lo_result = -r_acc[W-1:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_acc   <= '0;
      r_abs_b <= '0;
      r_op    <= Mult;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (i_load) begin
      r_acc   <= w_load_acc;
      r_abs_b <= w_abs_b;
      r_op    <= i_op;
      r_neg_q <= !i_is_unsigned && (i_op_a[W-1] ^ i_op_b[W-1]);
      r_neg_r <= !i_is_unsigned && i_op_a[W-1];
    end else if (i_step) begin
      r_acc <= (r_op == Mult) ? w_mult_next : w_div_next;
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO register pair.
// Runs radix-2 shift-add multiply / restoring divide one bit per cycle and
// stalls the core when HI/LO is consumed or a new operation is issued while
// one is still in flight.
// Optional feature macro: MDU_EARLY_EXIT_EN -- trivially resolvable
// operations (zero multiplicand/multiplier, |dividend| < |divisor|) skip the
// iterations and go straight to FIXUP.
// Ports:
//   clock : core clock, rising edge
//   reset : asynchronous, active-high
//   bus   : mdu_sequencer_if.slave (requests in; stall/busy/done/hi/lo out)
module mdu_sequencer
  import MduPkg::*;
#(
  parameter int DataWidth = 32
) (
  input logic            clock,
  input logic            reset,
  mdu_sequencer_if.slave bus
);

  localparam int CntW = count_width(DataWidth);

`ifdef MDU_EARLY_EXIT_EN
  localparam bit EarlyExitEn = 1'b1;
`else
  localparam bit EarlyExitEn = 1'b0;
`endif

  MduStateEnum          r_state;
  MduStateEnum          w_state_next;
  logic [CntW-1:0]      r_count;
  logic [DataWidth-1:0] r_hi;
  logic [DataWidth-1:0] r_lo;
  logic                 r_done;

  logic                 w_start;
  MduOpEnum             w_op;
  logic                 w_busy;
  logic                 w_load;
  logic                 w_step;
  logic                 w_trivial;
  logic [DataWidth-1:0] w_hi_result;
  logic [DataWidth-1:0] w_lo_result;

  assign w_start = bus.start_mult | bus.start_div;
  // Simultaneous requests resolve in favour of multiply.
  assign w_op    = bus.start_mult ? Mult : Div;
  assign w_busy  = (r_state != IDLE);

  mdu_datapath #(
    .DataWidth   (DataWidth),
    .EarlyExitEn (EarlyExitEn)
  ) u_datapath (
    .clock         (clock),
    .reset         (reset),
    .i_load        (w_load),
    .i_early_load  (w_trivial),
    .i_op          (w_op),
    .i_is_unsigned (bus.is_unsigned),
    .i_op_a        (bus.op_a),
    .i_op_b        (bus.op_b),
    .i_step        (w_step),
    .o_trivial     (w_trivial),
    .o_hi_result   (w_hi_result),
    .o_lo_result   (w_lo_result)
  );

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    if (bus.enable) begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            w_load = 1'b1;
            if (w_trivial)             w_state_next = FIXUP;
            else if (bus.start_mult)   w_state_next = MULT;
            else                       w_state_next = DIV;
          end
        end
        MULT, DIV: begin
          w_step = 1'b1;
          // Count holds the number of iterations still to run, including this one.
          if (r_count == CntW'(1)) w_state_next = FIXUP;
        end
        FIXUP:   w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_load)      r_count <= CntW'(DataWidth);
      else if (w_step) r_count <= r_count - CntW'(1);
    end
  end

  // HI/LO: FIXUP result has priority; MTHI/MTLO only land while idle and
  // are dropped when issued together with a start.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (bus.enable) begin
      if (r_state == FIXUP) begin
        r_hi <= w_hi_result;
        r_lo <= w_lo_result;
      end else if ((r_state == IDLE) && !w_start) begin
        if (bus.wr_hi) r_hi <= bus.wr_data;
        if (bus.wr_lo) r_lo <= bus.wr_data;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_done <= 1'b0;
    else       r_done <= bus.enable && (r_state == FIXUP);
  end

  assign bus.busy  = w_busy;
  assign bus.done  = r_done;
  assign bus.hi    = r_hi;
  assign bus.lo    = r_lo;
  assign bus.stall = w_busy & (bus.rd_hilo | bus.start_mult | bus.start_div |
                               bus.wr_hi | bus.wr_lo);

endmodule

// File: tb/tb_mdu_sequencer.sv
// Randomized self-checking bench for mdu_sequencer against an arithmetic
// reference model (64-bit integer multiply/divide plus the corner-case rules).
module tb_mdu_sequencer;

  localparam int W = 32;

`ifdef MDU_EARLY_EXIT_EN
  localparam bit EarlyEn = 1'b1;
`else
  localparam bit EarlyEn = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  mdu_sequencer_if #(.DataWidth(W)) bus ();

  mdu_sequencer #(.DataWidth(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference result {hi, lo} computed from plain integer arithmetic.
  function automatic logic [63:0] ref_result(input bit is_mult, input bit uns,
                                             input logic [W-1:0] a, input logic [W-1:0] b);
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    logic [63:0] ua = {32'b0, a};
    logic [63:0] ub = {32'b0, b};
    logic [63:0] p;
    if (is_mult) begin
      if (uns) p = ua * ub;
      else     p = 64'(sa * sb);
      return p;
    end
    if (b == '0) begin
      if (uns || sa >= 0) return {a, 32'hFFFF_FFFF};
      return {a, 32'h0000_0001};
    end
    if (uns) return {32'(ua % ub), 32'(ua / ub)};
    return {32'(sa % sb), 32'(sa / sb)};
  endfunction

  function automatic bit ref_trivial(input bit is_mult, input bit uns,
                                     input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ma = uns ? longint'({32'b0, a}) : (sa < 0 ? -sa : sa);
    longint mb = uns ? longint'({32'b0, b}) : (sb < 0 ? -sb : sb);
    if (is_mult) return (ma == 0) || (mb == 0);
    return (mb != 0) && (ma < mb);
  endfunction

  task automatic idle_inputs();
    bus.enable      = 1'b1;
    bus.start_mult  = 1'b0;
    bus.start_div   = 1'b0;
    bus.is_unsigned = 1'b0;
    bus.op_a        = '0;
    bus.op_b        = '0;
    bus.wr_hi       = 1'b0;
    bus.wr_lo       = 1'b0;
    bus.wr_data     = '0;
    bus.rd_hilo     = 1'b0;
  endtask

  // One MULT/DIV transaction; called at #1 after a rising edge with the unit idle.
  task automatic run_op(input bit is_mult, input bit uns, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit both_starts, input bit wr_at_start,
                        input bit stall_probe, input int fz_at, input int fz_len);
    logic [63:0] res = ref_result(is_mult, uns, a, b);
    int lat = (EarlyEn && ref_trivial(is_mult, uns, a, b)) ? 1 : W + 1;
    int n = 0;
    bus.start_mult  = is_mult | both_starts;
    bus.start_div   = !is_mult | both_starts;
    bus.is_unsigned = uns;
    bus.op_a        = a;
    bus.op_b        = b;
    if (wr_at_start) begin
      bus.wr_hi   = 1'b1;
      bus.wr_lo   = 1'b1;
      bus.wr_data = 32'hDEAD_BEEF;
    end
    @(posedge clock); #1;
    idle_inputs();
    bus.op_a = $urandom;
    bus.op_b = $urandom;
    bus.is_unsigned = 1'($urandom_range(0, 1));
    check_eq("busy_after_start", 64'(bus.busy), 64'd1);
    while (bus.busy && n < lat + fz_len + 5) begin
      bus.enable = !(n >= fz_at && n < fz_at + fz_len);
      if (stall_probe && n >= 4) begin
        bus.rd_hilo = 1'b1;
        bus.wr_hi   = 1'b1;
        bus.wr_data = $urandom;
        #1;
        check_eq("stall_busy", 64'(bus.stall), 64'd1);
      end
      @(posedge clock); #1;
      n++;
    end
    bus.enable = 1'b1;
    check_eq("latency", 64'(n), 64'(lat + fz_len));
    if (stall_probe) check_eq("stall_released", 64'(bus.stall), 64'd0);
    exp_hi = res[63:32];
    exp_lo = res[31:0];
    check_eq("done_pulse", 64'(bus.done), 64'd1);
    check_eq("hi", 64'(bus.hi), 64'(exp_hi));
    check_eq("lo", 64'(bus.lo), 64'(exp_lo));
    bus.rd_hilo = 1'b0;
    bus.wr_hi   = 1'b0;
    @(posedge clock); #1;
    check_eq("done_cleared", 64'(bus.done), 64'd0);
    check_eq("hi_hold", 64'(bus.hi), 64'(exp_hi));
    $display("op %s%s a=%h b=%h -> hi=%h lo=%h edges=%0d", is_mult ? "MULT" : "DIV",
             uns ? "U" : "", a, b, bus.hi, bus.lo, n);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4, 5:    return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin : stim
    bit done_seen;
    idle_inputs();
    #1 reset = 1'b1;
    @(posedge clock); @(posedge clock); #1;
    check_eq("rst_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_done", 64'(bus.done), 64'd0);
    check_eq("rst_hi", 64'(bus.hi), 64'd0);
    check_eq("rst_lo", 64'(bus.lo), 64'd0);
    reset = 1'b0;
    @(posedge clock); #1;
    check_eq("rst_stall", 64'(bus.stall), 64'd0);

    // Idle MTHI / MTLO.
    bus.wr_hi = 1'b1; bus.wr_data = 32'h0000_1234;
    @(posedge clock); #1;
    bus.wr_hi = 1'b0;
    check_eq("mthi", 64'(bus.hi), 64'h1234);
    bus.wr_lo = 1'b1; bus.wr_data = 32'h0000_ABCD;
    @(posedge clock); #1;
    bus.wr_lo = 1'b0;
    check_eq("mtlo", 64'(bus.lo), 64'hABCD);
    exp_hi = 32'h1234; exp_lo = 32'hABCD;

    // enable=0: no write, no start.
    bus.enable = 1'b0; bus.wr_hi = 1'b1; bus.wr_data = 32'h5555_5555; bus.start_mult = 1'b1;
    @(posedge clock); #1;
    check_eq("frozen_hi", 64'(bus.hi), 64'(exp_hi));
    check_eq("frozen_busy", 64'(bus.busy), 64'd0);
    idle_inputs();

    // Directed cases.
    run_op(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 0, 0);
    run_op(1'b0, 1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 0, 0);
    run_op(1'b0, 1'b1, 32'h0000_0007, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 0, 0);
    run_op(1'b0, 1'b0, 32'hFFFF_FFF9, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 0, 0);
    run_op(1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 0, 0);
    run_op(1'b1, 1'b0, 32'h0000_0003, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1, 0, 0);
    run_op(1'b0, 1'b0, 32'h0000_0064, 32'h0000_0007, 1'b0, 1'b1, 1'b0, 0, 0);
    run_op(1'b1, 1'b1, 32'h0001_0003, 32'h0000_0005, 1'b1, 1'b0, 1'b0, 0, 0);
    run_op(1'b0, 1'b1, 32'h0000_0003, 32'h0000_000A, 1'b0, 1'b0, 1'b0, 0, 0);
    run_op(1'b1, 1'b0, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 0, 2);

    // Reset in the middle of a divide (count 10).
    bus.start_div = 1'b1; bus.is_unsigned = 1'b1;
    bus.op_a = 32'hFFFF_FFF0; bus.op_b = 32'h0000_0003;
    @(posedge clock); #1;
    idle_inputs();
    repeat (22) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    check_eq("midrst_busy", 64'(bus.busy), 64'd0);
    check_eq("midrst_hi", 64'(bus.hi), 64'd0);
    check_eq("midrst_lo", 64'(bus.lo), 64'd0);
    @(posedge clock); #1 reset = 1'b0;
    done_seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock); #1;
      done_seen |= bus.done;
    end
    check_eq("midrst_no_done", 64'(done_seen), 64'd0);
    exp_hi = '0; exp_lo = '0;

    // Randomized operations.
    for (int i = 0; i < 30; i++) begin
      bit          m  = 1'($urandom_range(0, 1));
      bit          u  = 1'($urandom_range(0, 1));
      logic [W-1:0] a = pick();
      logic [W-1:0] b = pick();
      int lat   = (EarlyEn && ref_trivial(m, u, a, b)) ? 1 : W + 1;
      int fzl   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      int fza   = int'($urandom_range(0, lat - 1));
      bit probe = (lat > 6) && ($urandom_range(0, 3) == 0);
      bit both  = m && ($urandom_range(0, 3) == 0);
      bit wrs   = ($urandom_range(0, 3) == 0);
      run_op(m, u, a, b, both, wrs, probe, fza, fzl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
